// File: rtl/core_supervisor.sv
// Run-control supervisor: holds the core in reset, masks the settle window, latches the first fault.
// Optional build macro CORE_SUPERVISOR_AUTORESTART_EN enables budgeted automatic restart on fault.
module core_supervisor #(
   parameter int HOLD_CYCLES   = 4,
   parameter int SETTLE_CYCLES = 8,
   parameter int COUNT_W       = 16,
   parameter int MAX_RESTARTS  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [6:0]         exception_in,
   input  logic               host_halt_req,
   input  logic               host_clear,
   output logic               core_rst_out,
   output logic               running,
   output logic               halted,
   output logic [1:0]         cause,
   output logic [6:0]         exc_latched,
   output logic [COUNT_W-1:0] exc_count,
   output logic [COUNT_W-1:0] restart_count
);

   localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [1:0] S_RESET_HOLD = 2'd0;
   localparam logic [1:0] S_SETTLE     = 2'd1;
   localparam logic [1:0] S_RUN        = 2'd2;
   localparam logic [1:0] S_HALTED     = 2'd3;

   localparam logic [1:0] CAUSE_NONE      = 2'b00;
   localparam logic [1:0] CAUSE_FAULT     = 2'b01;
   localparam logic [1:0] CAUSE_HOST      = 2'b10;
   localparam logic [1:0] CAUSE_EXHAUSTED = 2'b11;

   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   if (HOLD_CYCLES < 1 || SETTLE_CYCLES < 1 || COUNT_W < 1 || MAX_RESTARTS < 0) begin : g_param_check
      $error("core_supervisor: invalid parameter values");
   end

   logic [1:0]         state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic [1:0]         cause_nx;
   logic [6:0]         exc_nx;
   logic [COUNT_W-1:0] exc_count_nx, restart_count_nx;
   logic [COUNT_W-1:0] exc_count_inc, restart_count_inc;

   assign exc_count_inc     = (exc_count == '1) ? exc_count : exc_count + COUNT_W'(1);
   assign restart_count_inc = (restart_count == '1) ? restart_count : restart_count + COUNT_W'(1);

   always_comb begin
      state_nx         = state;
      cnt_nx           = cnt;
      cause_nx         = cause;
      exc_nx           = exc_latched;
      exc_count_nx     = exc_count;
      restart_count_nx = restart_count;
      case (state)
         S_RESET_HOLD: begin
            if (cnt == '0) begin
               state_nx = S_SETTLE;
               cnt_nx   = SETTLE_LOAD;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_SETTLE: begin
            // exception_in deliberately not examined while the core fills its pipeline
            if (cnt == '0) begin
               state_nx = S_RUN;
               cause_nx = CAUSE_NONE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
         S_RUN: begin
            if (exception_in != '0) begin
               exc_nx       = exception_in;
               exc_count_nx = exc_count_inc;
`ifdef CORE_SUPERVISOR_AUTORESTART_EN
               if (restart_count < COUNT_W'(MAX_RESTARTS)) begin
                  state_nx         = S_RESET_HOLD;
                  cnt_nx           = HOLD_LOAD;
                  restart_count_nx = restart_count_inc;
                  cause_nx         = CAUSE_FAULT;
               end else begin
                  state_nx = S_HALTED;
                  cause_nx = CAUSE_EXHAUSTED;
               end
`else
               state_nx = S_HALTED;
               cause_nx = CAUSE_FAULT;
`endif
            end else if (host_halt_req) begin
               state_nx = S_HALTED;
               cause_nx = CAUSE_HOST;
            end
         end
         S_HALTED: begin
            if (host_clear) begin
               state_nx         = S_RESET_HOLD;
               cnt_nx           = HOLD_LOAD;
               cause_nx         = CAUSE_NONE;
               restart_count_nx = restart_count_inc;
            end
         end
         default: begin
            state_nx = S_RESET_HOLD;
            cnt_nx   = HOLD_LOAD;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they are registered yet track the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_RESET_HOLD;
         cnt           <= HOLD_LOAD;
         core_rst_out  <= 1'b1;
         running       <= 1'b0;
         halted        <= 1'b0;
         cause         <= CAUSE_NONE;
         exc_latched   <= '0;
         exc_count     <= '0;
         restart_count <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         core_rst_out  <= (state_nx == S_RESET_HOLD) || (state_nx == S_HALTED);
         running       <= (state_nx == S_RUN);
         halted        <= (state_nx == S_HALTED);
         cause         <= cause_nx;
         exc_latched   <= exc_nx;
         exc_count     <= exc_count_nx;
         restart_count <= restart_count_nx;
      end
   end

endmodule

// File: tb/tb_core_supervisor.sv
// Bench for core_supervisor: cycle-table scoreboard on the main instance plus counter saturation checks.
module tb_core_supervisor;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, hr, clr;
   logic [6:0]  exc;
   logic        core_rst_out, running, halted;
   logic [1:0]  cause;
   logic [6:0]  exc_latched;
   logic [15:0] exc_count, restart_count;

   logic        rst_s, hr_s, clr_s;
   logic [6:0]  exc_s;
   logic        core_rst_out_s, running_s, halted_s;
   logic [1:0]  cause_s;
   logic [6:0]  exc_latched_s;
   logic [1:0]  exc_count_s, restart_count_s;

   core_supervisor #(.HOLD_CYCLES(4), .SETTLE_CYCLES(8), .COUNT_W(16), .MAX_RESTARTS(3)) dut (
      .clk(clk), .rst(rst), .exception_in(exc), .host_halt_req(hr), .host_clear(clr),
      .core_rst_out(core_rst_out), .running(running), .halted(halted), .cause(cause),
      .exc_latched(exc_latched), .exc_count(exc_count), .restart_count(restart_count));

   core_supervisor #(.HOLD_CYCLES(4), .SETTLE_CYCLES(8), .COUNT_W(2), .MAX_RESTARTS(3)) dut_sat (
      .clk(clk), .rst(rst_s), .exception_in(exc_s), .host_halt_req(hr_s), .host_clear(clr_s),
      .core_rst_out(core_rst_out_s), .running(running_s), .halted(halted_s), .cause(cause_s),
      .exc_latched(exc_latched_s), .exc_count(exc_count_s), .restart_count(restart_count_s));

   typedef struct {
      logic        rst;
      logic [6:0]  exc;
      logic        hr, clr;
      logic        crst, run, hlt;
      logic [1:0]  cause;
      logic [6:0]  lat;
      logic [15:0] ec, rc;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void add(input logic r, input logic [6:0] e, input logic h, input logic c,
                               input logic crst, input logic run, input logic hlt, input logic [1:0] ca,
                               input logic [6:0] lat, input logic [15:0] ec, input logic [15:0] rc);
      vec_t v;
      v.rst = r; v.exc = e; v.hr = h; v.clr = c;
      v.crst = crst; v.run = run; v.hlt = hlt; v.cause = ca;
      v.lat = lat; v.ec = ec; v.rc = rc;
      tbl.push_back(v);
   endfunction

   // 3 more hold cycles, 8 settle cycles, then the edge that enters RUN.
   function automatic void add_bringup(input logic [6:0] e, input logic h, input logic [6:0] lat,
                                       input logic [15:0] ec, input logic [15:0] rc);
      for (int i = 0; i < 3; i++) add(1'b0, e, h, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, lat, ec, rc);
      for (int i = 0; i < 8; i++) add(1'b0, e, h, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, lat, ec, rc);
      add(1'b0, e, h, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, lat, ec, rc);
   endfunction

   task automatic wait_running_s(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (running_s) ok = 1'b1;
      end
   endtask

   task automatic wait_running(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk); #1;
         if (running) ok = 1'b1;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t e;
      bit   ok;
      int   k;
      rst = 1'b1; exc = '0; hr = 1'b0; clr = 1'b0;
      rst_s = 1'b1; exc_s = '0; hr_s = 1'b0; clr_s = 1'b0;

`ifdef CORE_SUPERVISOR_AUTORESTART_EN
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      for (k = 1; k <= 4; k++) begin
         wait_running(ok);
         chk($sformatf("run_reached_%0d", k), {63'd0, ok}, 64'd1);
         chk($sformatf("cause_clear_in_run_%0d", k), {62'd0, cause}, 64'd0);
         @(negedge clk); exc = 7'h10;
         @(posedge clk); #1;
         @(negedge clk); exc = '0;
         if (k <= 3)
            chk($sformatf("autorestart_%0d", k),
                {27'd0, core_rst_out, halted, cause, exc_count, restart_count},
                {27'd0, 1'b1, 1'b0, 2'b01, 16'(k), 16'(k)});
         else
            chk("budget_exhausted",
                {27'd0, core_rst_out, halted, cause, exc_count, restart_count},
                {27'd0, 1'b1, 1'b1, 2'b11, 16'd4, 16'd3});
      end
      chk("exhausted_latch", {57'd0, exc_latched}, 64'h10);
`else
      add(1, 7'h00, 0, 0, 1, 0, 0, 2'd0, 7'h00, 0, 0);
      add(1, 7'h00, 0, 0, 1, 0, 0, 2'd0, 7'h00, 0, 0);
      add_bringup(7'h7F, 0, 7'h00, 0, 0);
      add(0, 7'h00, 0, 0, 0, 1, 0, 2'd0, 7'h00, 0, 0);
      add(0, 7'h08, 0, 0, 1, 0, 1, 2'd1, 7'h08, 1, 0);
      add(0, 7'h7F, 1, 0, 1, 0, 1, 2'd1, 7'h08, 1, 0);
      add(0, 7'h00, 0, 1, 1, 0, 0, 2'd0, 7'h08, 1, 1);
      add_bringup(7'h00, 0, 7'h08, 1, 1);
      add(0, 7'h40, 1, 0, 1, 0, 1, 2'd1, 7'h40, 2, 1);
      add(0, 7'h00, 0, 1, 1, 0, 0, 2'd0, 7'h40, 2, 2);
      add_bringup(7'h00, 0, 7'h40, 2, 2);
      add(0, 7'h00, 1, 0, 1, 0, 1, 2'd2, 7'h40, 2, 2);
      add(0, 7'h00, 0, 1, 1, 0, 0, 2'd0, 7'h40, 2, 3);
      add(0, 7'h00, 0, 0, 1, 0, 0, 2'd0, 7'h40, 2, 3);
      add(1, 7'h00, 0, 0, 1, 0, 0, 2'd0, 7'h00, 0, 0);
      add_bringup(7'h00, 1, 7'h00, 0, 0);
      add(0, 7'h00, 1, 0, 1, 0, 1, 2'd2, 7'h00, 0, 0);
      add(0, 7'h00, 1, 1, 1, 0, 0, 2'd0, 7'h00, 0, 1);
      add_bringup(7'h00, 0, 7'h00, 0, 1);
      add(0, 7'h02, 0, 0, 1, 0, 1, 2'd1, 7'h02, 1, 1);

      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst; exc = tbl[i].exc; hr = tbl[i].hr; clr = tbl[i].clr;
         exp_q.push_back(tbl[i]);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         chk($sformatf("row_%0d", i),
             {20'd0, core_rst_out, running, halted, cause, exc_latched, exc_count, restart_count},
             {20'd0, e.crst, e.run, e.hlt, e.cause, e.lat, e.ec, e.rc});
      end
      @(negedge clk); exc = '0; hr = 1'b0; clr = 1'b0;

      rst_s = 1'b0;
      for (k = 1; k <= 5; k++) begin
         wait_running_s(ok);
         chk($sformatf("sat_run_%0d", k), {63'd0, ok}, 64'd1);
         @(negedge clk); exc_s = 7'h01;
         @(posedge clk); #1;
         chk($sformatf("sat_exc_%0d", k), {61'd0, halted_s, exc_count_s},
             {61'd0, 1'b1, (k > 3) ? 2'd3 : 2'(k)});
         @(negedge clk); exc_s = '0; clr_s = 1'b1;
         @(posedge clk); #1;
         chk($sformatf("sat_restart_%0d", k), {61'd0, halted_s, restart_count_s},
             {61'd0, 1'b0, (k > 3) ? 2'd3 : 2'(k)});
         @(negedge clk); clr_s = 1'b0;
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/core_supervisor.md
# core_supervisor

Run-control block on the far side of the core's exception and reset pins. It consumes the core's 7-bit `exception_out` and drives the core's `rst_in`. It holds the core in reset after system reset and after any fault or host halt, and latches the first fault cause for the host. It also counts faults and restarts.

## Interface
Parameters:
- `HOLD_CYCLES`, 4: cycles `core_rst_out` stays high per reset episode. Minimum 1.
- `SETTLE_CYCLES`, 8: cycles after reset release during which `exception_in` is ignored, covering the core's reset stretch and pipeline fill. Minimum 1.
- `COUNT_W`, 16: width of `exc_count` and `restart_count`.
- `MAX_RESTARTS`, 3: auto-restart budget. Used only with `CORE_SUPERVISOR_AUTORESTART_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `exception_in`  in  7  core `exception_out`. Bit 6 is the decode exception, bits 5:3 the ALU exception, bits 2:0 the memory exception. Any nonzero value is a fault.
- `host_halt_req`  in  1  level; requests a halt while running.
- `host_clear`  in  1  single-cycle pulse; restarts from HALTED.
- `core_rst_out`  out  1  drives core `rst_in`.
- `running`  out  1  high in RUN only.
- `halted`  out  1  high in HALTED only.
- `cause`  out  2  halt cause: 00 none, 01 fault, 10 host halt, 11 restart budget exhausted.
- `exc_latched`  out  7  `exception_in` value that caused the last fault halt or restart.
- `exc_count`  out  COUNT_W  faults seen in RUN, saturating.
- `restart_count`  out  COUNT_W  reset episodes after the initial one, saturating.

## Operation
- FSM states: RESET_HOLD, SETTLE, RUN, HALTED. A single down-counter `cnt` is shared by RESET_HOLD and SETTLE. Its width is `$clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1)`.
- RESET_HOLD:
  - `core_rst_out`=1.
  - When `cnt`==0, go to SETTLE with `cnt`=SETTLE_CYCLES-1. Otherwise decrement `cnt`.
- SETTLE:
  - `core_rst_out`=0 and `exception_in` is ignored.
  - When `cnt`==0, go to RUN. Otherwise decrement `cnt`.
- RUN:
  - Nonzero `exception_in`: latch it into `exc_latched`, set `cause`=01, increment `exc_count` (saturating at all-ones), and go to HALTED.
  - Else if `host_halt_req`: set `cause`=10, leave `exc_latched` unchanged, and go to HALTED.
  - A fault wins over a simultaneous `host_halt_req`.
- HALTED:
  - `core_rst_out`=1; the core has no stall, so it is frozen by reset.
  - `host_clear`: increment `restart_count` (saturating), go to RESET_HOLD with `cnt`=HOLD_CYCLES-1, and clear `cause` to 00. `exc_latched` is retained.
- `host_clear` is ignored outside HALTED. `host_halt_req` is ignored outside RUN. A halt request held through restart re-halts on the first RUN cycle.
- `rst` asserted in any state, including mid-hold or mid-settle, forces reset values on the next edge.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Reset values:
  - state RESET_HOLD, `cnt`=HOLD_CYCLES-1.
  - `core_rst_out`=1, `running`=0, `halted`=0.
  - `cause`=00, `exc_latched`=0.
  - `exc_count`=0, `restart_count`=0.
- Fault sampled at edge E: `halted`=1, `core_rst_out`=1 and `running`=0 are visible after E. The latency is 1 cycle.
- After `rst` deasserts:
  - `core_rst_out` stays high for exactly HOLD_CYCLES cycles.
  - It is then low for SETTLE_CYCLES cycles before `running` rises.
- `host_clear` sampled at edge E: `halted` falls after E, and `core_rst_out` stays high for HOLD_CYCLES cycles counted from E.

## Configuration
- `CORE_SUPERVISOR_AUTORESTART_EN`, defined:
  - A fault in RUN with `restart_count` < MAX_RESTARTS does the latch and `exc_count` update as normal, then goes directly to RESET_HOLD with `cnt`=HOLD_CYCLES-1. It increments `restart_count` and sets `cause`=01.
  - `cause` clears to 00 on reaching RUN.
  - A fault with `restart_count` ≥ MAX_RESTARTS goes to HALTED with `cause`=11.
  - `host_clear` restarts regardless of the budget.
- `CORE_SUPERVISOR_AUTORESTART_EN`, undefined: every fault goes to HALTED with `cause`=01, and MAX_RESTARTS is unused.

## Test plan
- Reset bring-up, HOLD=4, SETTLE=8: release `rst` → `core_rst_out`=1 for 4 cycles, then 0; `running`=1 on cycle 12.
- SETTLE masking: drive `exception_in`=7'h7F during SETTLE → no halt and `exc_count`=0. Drive 7'h08 in RUN → `halted`=1 after 1 cycle, `exc_latched`=7'h08, `cause`=01, `exc_count`=1.
- Fault and halt together in RUN: `exception_in`=7'h40 with `host_halt_req`=1 → `cause`=01, `exc_latched`=7'h40. Then `host_clear` → `restart_count`=1, RESET_HOLD 4 cycles, `cause`=00.
- Host halt, then `rst` mid-RESET_HOLD after `host_clear`: `host_halt_req` → `cause`=10, `exc_latched` unchanged. `host_clear`, then `rst` on hold cycle 2 → all outputs return to reset values and the full 4+8 sequence restarts.
- Saturation: COUNT_W=2, 5 fault/clear rounds → `exc_count`=3 and `restart_count`=3.
- AUTORESTART_EN, MAX_RESTARTS=3: 4 consecutive faults → first 3 self-restart with `restart_count` 1, 2, 3; the 4th gives `halted`=1, `cause`=11, `exc_count`=4.
